fetch_unit_mt: RTL
==================

// Module: fetch_unit_mt
// PURPOSE
//  Parametrised multi-thread fetch / load-store front end for the CPU core.
//  Serves core requests either from a per-thread register bank, mapped at the top of the address space,
//  or from the external W_ bus master port.
//  Replaces the fixed 32-bit, 4-thread FETCH: thread count, register count, widths and region base are
//  parameters; the bus side gains a strobe / wait-state handshake.
// PARAMETERS
//  DATA_W      32            data width of core and bus sides
//  ADDR_W      32            address width
//  THREADS     4             hardware threads (power of 2, >=2)
//  NREGS       16            registers per thread (power of 2, >=2)
//  REG_BASE    32'hFFFF_FFF0 base of register window; NREGS-aligned; ADDR_W bits wide
//  TIMEOUT_CYC 255           bus wait limit in cycles (used only with FETCH_TIMEOUT_EN)
// PORTS
//  clk         in   1                clock; all logic rising-edge
//  rst_n       in   1                asynchronous, active-low reset
//  f_enable    in   1                request valid; held high until ack seen
//  write_mode  in   1                1 = write, 0 = read
//  addr        in   ADDR_W           request address
//  data_i      in   DATA_W           write data
//  thread      in   $clog2(THREADS)  requesting thread id
//  data_o      out  DATA_W           read data, valid while ack=1
//  ack         out  1                request complete
//  err         out  1                bus timeout flag, valid with ack
//  W_STB       out  1                bus request strobe
//  W_ADDR      out  ADDR_W           bus address
//  W_DATA_O    out  DATA_W           bus write data
//  W_WRITE     out  1                bus write enable
//  W_ACK       in   1                bus completion
//  W_DATA_I    in   DATA_W           bus read data
// BEHAVIOUR
//  Reset
//   - rst_n=0 asynchronously forces state IDLE.
//   - Outputs: ack=0, err=0, W_STB=0, W_WRITE=0, data_o=0, W_ADDR=0, W_DATA_O=0.
//   - Clears all THREADS*NREGS registers to 0.
//   - Reset during BUS abandons the transaction; W_STB drops immediately.
//  Decode
//   - is_reg = (addr[ADDR_W-1:$clog2(NREGS)] == REG_BASE[ADDR_W-1:$clog2(NREGS)]).
//   - Register index = addr[$clog2(NREGS)-1:0]; bank index = thread.
//  FSM IDLE -> (REG | BUS) -> DONE -> IDLE
//   - IDLE, f_enable=1, is_reg:
//       write: reg[thread][idx] <= data_i at this edge.
//       read:  data_o <= reg[thread][idx].
//       ack=1 at this edge (1-cycle latency); go to DONE.
//   - IDLE, f_enable=1, !is_reg:
//       W_STB=1, W_ADDR=addr, W_WRITE=write_mode, W_DATA_O=data_i are registered; go to BUS.
//       Request fields are captured at acceptance; later changes to addr, data_i or thread are ignored
//       until the next acceptance.
//   - BUS:
//       Hold W_ outputs stable.
//       On W_ACK=1: W_STB <= 0; data_o <= W_DATA_I (reads only); ack <= 1; go to DONE.
//       Latency is 1 + bus wait cycles.
//   - DONE:
//       ack held 1 and data_o held stable while f_enable=1.
//       f_enable=0 -> ack <= 0, err <= 0, go to IDLE.
//       Four-phase handshake: a new request needs f_enable low for at least 1 cycle.
//  Boundary rules
//   - f_enable dropped in BUS: the transaction still completes; ack pulses for 1 cycle, then IDLE.
//   - W_ACK outside BUS: ignored.
//   - Register writes in one thread never alter another thread's bank.
//   - Data outside the register window never touches the regfile.
// CONFIGURATION
//  FETCH_TIMEOUT_EN
//   Defined:
//    - A cycle counter runs in BUS; TIMEOUT_CYC cycles without W_ACK -> W_STB <= 0, ack <= 1, err <= 1,
//      data_o <= {DATA_W{1'b1}}, go to DONE.
//    - The counter clears on every entry to BUS.
//   Undefined:
//    - No counter; BUS waits indefinitely; err tied 0.
// STRUCTURE
//  fetch_pkg
//   - State encoding (IDLE, BUS, DONE).
//   - Localparams TID_W = $clog2(THREADS), IDX_W = $clog2(NREGS).
//   - Region-decode function is_reg_addr().
//  fetch_regfile (sub-module)
//   - THREADS*NREGS x DATA_W, async clear, 1 write port, 1 async read port, addressed {thread, idx}.
//  fetch_unit_mt
//   - Top level: FSM, bus master registers and optional timeout counter.
// TESTING
//  1. Write r0 t0 = 32'h1111_1111 -> ack=1 after 1 edge; f_enable=0 -> ack=0 after 1 edge.
//  2. Write r1 t1 = 32'h2222_2222 and r1 t0 = 32'h2222_1111.
//     Read r1 t1 -> data_o=32'h2222_2222; read r1 t0 -> data_o=32'h2222_1111.
//  3. Read addr 32'h0000_1000 with W_ACK after 3 cycles and W_DATA_I=32'hDEAD_BEEF.
//     -> W_STB=1 for 3 cycles with W_ADDR=32'h1000; then ack=1, data_o=32'hDEAD_BEEF.
//  4. Bus write, then pull rst_n low mid-BUS.
//     -> W_STB=0 and ack=0 immediately; all registers read back 0 after reset.
//  5. f_enable held high across two register requests -> second request not accepted until f_enable
//     is low for 1 cycle.
//  6. FETCH_TIMEOUT_EN, TIMEOUT_CYC=8, W_ACK never asserted.
//     -> ack=1, err=1, data_o=32'hFFFF_FFFF 8 cycles after W_STB rises.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the multi-thread fetch / load-store front end.
//   - fetch_state_e : FSM state encoding (IDLE, BUS, DONE)
//   - TID_W, IDX_W  : thread-id and register-index widths for the default configuration
//                     (4 threads, 16 registers per thread)
//   - is_reg_addr() : register-window decode, generic over address and index width
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StDone = 2'd2
  } fetch_state_e;

  localparam int unsigned THREADS_DEF = 4;
  localparam int unsigned NREGS_DEF   = 16;
  localparam int unsigned TID_W       = $clog2(THREADS_DEF);
  localparam int unsigned IDX_W       = $clog2(NREGS_DEF);

  // Widest address the decode helper accepts; callers zero-extend into it.
  localparam int unsigned MaxAddrW = 64;

  // True when addr falls in the NREGS-aligned window starting at base. Only the bits
  // above the register index take part in the compare.
  function automatic logic is_reg_addr(input logic [MaxAddrW-1:0] addr,
                                       input logic [MaxAddrW-1:0] base,
                                       input int unsigned         idx_w);
    return (addr >> idx_w) == (base >> idx_w);
  endfunction

endpackage

// File: rtl/fetch_regfile.sv
// Per-thread register banks, flattened into one THREADS*NREGS entry array.
// One synchronous write port and one asynchronous read port sharing the address
// {thread, idx}; the whole array clears on asynchronous reset.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low clear
//   we_i    : write enable
//   addr_i  : entry address {thread, idx}
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
module fetch_regfile #(
  parameter int unsigned DataW   = 32,
  parameter int unsigned Entries = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [$clog2(Entries)-1:0] addr_i,
  input  logic [DataW-1:0]           wdata_i,
  output logic [DataW-1:0]           rdata_o
);

  logic [DataW-1:0] mem_q [Entries];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Entries); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/fetch_unit_mt.sv
// Multi-thread fetch / load-store front end. Core requests that hit the register
// window at REG_BASE are served from a per-thread register bank in one cycle; all
// other addresses go out on the W_ bus master port with a strobe / wait-state
// handshake. The core side is a four-phase f_enable / ack handshake.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   - bus transactions give up after TIMEOUT_CYC cycles without W_ACK,
//               completing with err=1 and data_o all ones
//   undefined - the bus waits indefinitely and err is tied low
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   f_enable, write_mode   : request valid (held until ack), 1 = write
//   addr, data_i, thread   : request address, write data, requesting thread
//   data_o, ack, err       : read data and completion / timeout flags
//   W_STB, W_ADDR,
//   W_DATA_O, W_WRITE      : registered bus master request
//   W_ACK, W_DATA_I        : bus completion and read data
module fetch_unit_mt
  import fetch_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        THREADS     = 4,
  parameter int unsigned        NREGS       = 16,
  parameter logic [ADDR_W-1:0]  REG_BASE    = ADDR_W'(32'hFFFF_FFF0),
  parameter int unsigned        TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       f_enable,
  input  logic                       write_mode,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [$clog2(THREADS)-1:0] thread,
  output logic [DATA_W-1:0]          data_o,
  output logic                       ack,
  output logic                       err,
  output logic                       W_STB,
  output logic [ADDR_W-1:0]          W_ADDR,
  output logic [DATA_W-1:0]          W_DATA_O,
  output logic                       W_WRITE,
  input  logic                       W_ACK,
  input  logic [DATA_W-1:0]          W_DATA_I
);

  localparam int unsigned ThreadW = $clog2(THREADS);
  localparam int unsigned IndexW  = $clog2(NREGS);

  fetch_state_e state_q, state_d;

  logic              ack_q, ack_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              stb_q, stb_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wwrite_q, wwrite_d;

`ifdef FETCH_TIMEOUT_EN
  // Counts 0 .. TIMEOUT_CYC-1 while waiting in BUS.
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  logic                      is_reg;
  logic                      rf_we;
  logic [DATA_W-1:0]         rf_rdata;
  logic [ThreadW+IndexW-1:0] rf_addr;

  assign is_reg  = is_reg_addr(MaxAddrW'(addr), MaxAddrW'(REG_BASE), IndexW);
  assign rf_addr = {thread, addr[IndexW-1:0]};

  fetch_regfile #(
    .DataW   (DATA_W),
    .Entries (THREADS * NREGS)
  ) u_regfile (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (rf_we),
    .addr_i  (rf_addr),
    .wdata_i (data_i),
    .rdata_o (rf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    data_d   = data_q;
    stb_d    = stb_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wwrite_d = wwrite_q;
    rf_we    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (f_enable) begin
          if (is_reg) begin
            if (write_mode) begin
              rf_we = 1'b1;
            end else begin
              data_d = rf_rdata;
            end
            ack_d   = 1'b1;
            state_d = StDone;
          end else begin
            // Request is captured here; the core may change its inputs afterwards.
            stb_d    = 1'b1;
            waddr_d  = addr;
            wdata_d  = data_i;
            wwrite_d = write_mode;
`ifdef FETCH_TIMEOUT_EN
            cnt_d    = '0;
`endif
            state_d  = StBus;
          end
        end
      end

      StBus: begin
        if (W_ACK) begin
          stb_d = 1'b0;
          if (!wwrite_q) begin
            data_d = W_DATA_I;
          end
          ack_d   = 1'b1;
          state_d = StDone;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          data_d  = '1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      StDone: begin
        // A new request is only accepted after f_enable has been seen low.
        if (!f_enable) begin
          ack_d   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ack_q    <= 1'b0;
      data_q   <= '0;
      stb_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wwrite_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      stb_q    <= stb_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wwrite_q <= wwrite_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign data_o   = data_q;
  assign ack      = ack_q;
  assign W_STB    = stb_q;
  assign W_ADDR   = waddr_q;
  assign W_DATA_O = wdata_q;
  assign W_WRITE  = wwrite_q;
`ifdef FETCH_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
